instr_fetch_mem: RTL and testbench

Parametrised instruction memory for the 5-stage RISC-V pipeline, replacing the single-port combinational fetch memory. It serves word fetches over a valid/ready request/response handshake with one-cycle latency, buffering up to two responses so IF can stall without losing fetched words. It flags misaligned and out-of-range PCs, supports a redirect flush, and has a byte-enabled load port for boot and testbench program loading.

---
 rtl/instr_fetch_mem.sv | 135 +++++++++++++
 tb/tb_instr_fetch_mem.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem
//   Parametrised instruction memory for the 5-stage pipeline. Serves word
//   fetches over a valid/ready handshake with one-cycle latency into a
//   2-entry response FIFO, so IF can stall without losing fetched words.
//   Misaligned and out-of-range PCs produce faulted NOP responses. A flush
//   discards buffered responses; a byte-enabled load port writes the array.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready/req_pc fetch request handshake and byte PC
//   rsp_valid/rsp_ready        response handshake (FIFO head)
//   rsp_instr/rsp_pc/rsp_fault head entry: word, PC, fault (01 misaligned,
//                              10 out of range)
//   flush                      drop all buffered responses
//   ld_en/ld_addr/ld_data/ld_be load-port write (byte lanes)
module instr_fetch_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_pc,
  output logic [1:0]            rsp_fault,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  input  logic [3:0]            ld_be
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Word indices are compared at a width that holds both any address-derived
  // index and DEPTH_WORDS, so the range check never truncates either side.
  localparam int unsigned CMP_W = ADDR_WIDTH + 32;
  localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [CMP_W-1:0] req_widx;
  logic [CMP_W-1:0] ld_widx;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] ld_idx;

  assign req_widx = CMP_W'(req_pc >> 2);
  assign ld_widx  = CMP_W'(ld_addr >> 2);
  assign req_idx  = req_widx[IDX_W-1:0];
  assign ld_idx   = ld_widx[IDX_W-1:0];

  // Fetch decode: misalignment takes priority over range.
  logic [31:0] req_instr;
  logic [1:0]  req_fault;

  always_comb begin
    req_fault = 2'b00;
    req_instr = NOP_INSTR;
    if (req_pc[1:0] != 2'b00) begin
      req_fault = 2'b01;
    end else if (req_widx >= DEPTH_C) begin
      req_fault = 2'b10;
    end else begin
      req_instr = mem_q[req_idx];
    end
  end

  // Storage is not reset. The fetch read above samples the old word, so a
  // same-edge load and fetch to one word gives read-before-write.
  always_ff @(posedge clk) begin
    if (ld_en && (ld_widx < DEPTH_C)) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (ld_be[k]) begin
          mem_q[ld_idx][8*k +: 8] <= ld_data[8*k +: 8];
        end
      end
    end
  end

  // Two-entry response FIFO.
  logic [31:0]           fifo_instr_q [2];
  logic [ADDR_WIDTH-1:0] fifo_pc_q    [2];
  logic [1:0]            fifo_fault_q [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  push, pop, wr_ptr;

  assign req_ready = rst_n && !flush && (count_q != 2'd2);
  assign rsp_valid = (count_q != 2'd0);
  assign rsp_instr = fifo_instr_q[rd_ptr_q];
  assign rsp_pc    = fifo_pc_q[rd_ptr_q];
  assign rsp_fault = fifo_fault_q[rd_ptr_q];

  always_comb begin
    push     = req_valid && req_ready;
    pop      = rsp_valid && rsp_ready && !flush;
    // Free slot sits one past the head when exactly one entry is held.
    wr_ptr   = rd_ptr_q ^ count_q[0];
    rd_ptr_d = pop ? !rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Entries reset to NOP/0/00 so the head shows the reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= NOP_INSTR;
        fifo_pc_q[i]    <= '0;
        fifo_fault_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        fifo_instr_q[wr_ptr] <= req_instr;
        fifo_pc_q[wr_ptr]    <= req_pc;
        fifo_fault_q[wr_ptr] <= req_fault;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;

  localparam int unsigned DEPTH = 20;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  fault;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, flush, ld_en;
  logic [31:0] req_pc, rsp_instr, rsp_pc, ld_addr, ld_data;
  logic [1:0]  rsp_fault;
  logic [3:0]  ld_be;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] model_mem [DEPTH];
  rsp_t        q [$];

  always #5 clk = ~clk;

  instr_fetch_mem #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_WIDTH (32),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_pc   (req_pc),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_pc   (rsp_pc),
    .rsp_fault(rsp_fault),
    .flush    (flush),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_be    (ld_be)
  );

  // Reference behaviour for one clock edge, using the inputs now applied.
  task automatic model_edge();
    rsp_t e;
    logic acc, pop;
    e.pc    = req_pc;
    e.instr = NOP;
    e.fault = 2'b00;
    if (req_pc % 4 != 0) e.fault = 2'b01;
    else if (req_pc / 4 >= DEPTH) e.fault = 2'b10;
    else e.instr = model_mem[req_pc / 4];
    if (!rst_n) begin
      q.delete();
    end else begin
      acc = req_valid && !flush && (q.size() < 2);
      pop = (q.size() != 0) && rsp_ready && !flush;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    if (ld_en && (ld_addr / 4 < DEPTH))
      for (int k = 0; k < 4; k++)
        if (ld_be[k]) model_mem[ld_addr / 4][8*k +: 8] = ld_data[8*k +: 8];
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_pc = 0; rsp_ready = 0; flush = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0; ld_be = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    repeat (2) tick();
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b00)
      $display("FAIL reset_handshake got valid/ready=%b exp 00", {rsp_valid, req_ready});
    else n_pass++;
    n_checks++;
    if ({rsp_instr, rsp_pc, rsp_fault} !== {NOP, 32'h0, 2'b00})
      $display("FAIL reset_head got %h/%h/%b exp %h/0/00", rsp_instr, rsp_pc, rsp_fault, NOP);
    else n_pass++;
    rst_n = 1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", req_ready);
    else n_pass++;
    tick();
  endtask

  task automatic init_mem();
    for (int w = 0; w < DEPTH; w++) begin
      ld_en = 1; ld_addr = 4 * w; ld_data = $urandom; ld_be = 4'hF;
      tick();
    end
    ld_en = 0;
  endtask

  task automatic test_basic();
    ld_en = 1; ld_be = 4'hF; ld_addr = 0; ld_data = 32'h00310083;
    tick();
    ld_addr = 4; ld_data = 32'h40628233;
    tick();
    ld_en = 0;
    rsp_ready = 1; req_valid = 1; req_pc = 0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL basic_ready0 got %b exp 1", req_ready); else n_pass++;
    tick();
    req_pc = 4;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault} !== {2'b11, 32'h00310083, 32'h0, 2'b00})
      $display("FAIL basic_rsp0 got %b%b %h/%h/%b exp 11 00310083/0/00",
               req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault);
    else n_pass++;
    tick();
    req_valid = 0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_instr, rsp_pc, rsp_fault} !== {1'b1, 32'h40628233, 32'h4, 2'b00})
      $display("FAIL basic_rsp1 got %b %h/%h/%b exp 1 40628233/4/00",
               rsp_valid, rsp_instr, rsp_pc, rsp_fault);
    else n_pass++;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL basic_drain got %b exp 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    rsp_ready = 0; req_valid = 1; req_pc = 0;
    tick();
    req_pc = 4;
    tick();
    req_pc = 8;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_pc} !== {2'b01, 32'h0})
      $display("FAIL bp_full got ready=%b valid=%b pc=%h exp 0 1 0", req_ready, rsp_valid, rsp_pc);
    else n_pass++;
    tick();
    n_checks++;
    if ({req_ready, rsp_instr, rsp_pc} !== {1'b0, 32'h00310083, 32'h0})
      $display("FAIL bp_stable got ready=%b %h/%h exp 0 00310083/0", req_ready, rsp_instr, rsp_pc);
    else n_pass++;
    rsp_ready = 1;
    tick();
    n_checks++;
    if ({req_ready, rsp_pc} !== {1'b1, 32'h4})
      $display("FAIL bp_after_pop got ready=%b pc=%h exp 1 4", req_ready, rsp_pc);
    else n_pass++;
    tick();
    req_valid = 0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_instr, rsp_pc, rsp_fault} !== {1'b1, model_mem[2], 32'h8, 2'b00})
      $display("FAIL bp_pc8 got %b %h/%h/%b exp 1 %h/8/00",
               rsp_valid, rsp_instr, rsp_pc, rsp_fault, model_mem[2]);
    else n_pass++;
    tick();
  endtask

  task automatic test_faults();
    logic [31:0] pcs [4];
    logic [31:0] exp_i [4];
    logic [1:0]  exp_f [4];
    pcs[0] = 32'h2;           exp_f[0] = 2'b01; exp_i[0] = NOP;
    pcs[1] = 4 * DEPTH;       exp_f[1] = 2'b10; exp_i[1] = NOP;
    pcs[2] = 4 * DEPTH + 1;   exp_f[2] = 2'b01; exp_i[2] = NOP;
    pcs[3] = 4 * DEPTH - 4;   exp_f[3] = 2'b00; exp_i[3] = model_mem[DEPTH-1];
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_pc = pcs[i];
      tick();
      req_valid = 0;
      #1;
      n_checks++;
      if ({rsp_valid, rsp_instr, rsp_pc, rsp_fault} !== {1'b1, exp_i[i], pcs[i], exp_f[i]})
        $display("FAIL fault_%0d got %b %h/%h/%b exp 1 %h/%h/%b", i,
                 rsp_valid, rsp_instr, rsp_pc, rsp_fault, exp_i[i], pcs[i], exp_f[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_flush();
    rsp_ready = 0; req_valid = 1; req_pc = 0;
    tick();
    req_pc = 4;
    tick();
    flush = 1; req_pc = 8;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL flush_ready got %b exp 0", req_ready); else n_pass++;
    tick();
    flush = 0; req_valid = 0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL flush_empty got %b exp 0", rsp_valid); else n_pass++;
    req_valid = 1; req_pc = 0; rsp_ready = 1;
    tick();
    req_valid = 0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_pc, rsp_instr} !== {1'b1, 32'h0, model_mem[0]})
      $display("FAIL flush_refetch got %b %h/%h exp 1 0/%h", rsp_valid, rsp_pc, rsp_instr, model_mem[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL flush_single got %b exp 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_rbw();
    ld_en = 1; ld_addr = 32'hC; ld_be = 4'hF; ld_data = 32'hAABBCCDD;
    tick();
    ld_be = 4'b0010; ld_data = 32'h00001100;
    req_valid = 1; req_pc = 32'hC; rsp_ready = 1;
    tick();
    ld_en = 0;
    #1;
    n_checks++;
    if (rsp_instr !== 32'hAABBCCDD) $display("FAIL rbw_old got %h exp aabbccdd", rsp_instr); else n_pass++;
    tick();
    req_valid = 0;
    #1;
    n_checks++;
    if (rsp_instr !== 32'hAABB11DD) $display("FAIL rbw_new got %h exp aabb11dd", rsp_instr); else n_pass++;
    // Out-of-range load must not disturb any word.
    ld_en = 1; ld_addr = 4 * DEPTH; ld_be = 4'hF; ld_data = 32'hDEADBEEF;
    tick();
    ld_en = 0; req_valid = 1; req_pc = 32'hC;
    tick();
    req_valid = 0;
    #1;
    n_checks++;
    if (rsp_instr !== 32'hAABB11DD) $display("FAIL oor_load got %h exp aabb11dd", rsp_instr); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      req_pc = (r < 7) ? 4 * $urandom_range(0, DEPTH - 1) : $urandom_range(0, 4 * DEPTH + 7);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 11) == 0);
      ld_en = ($urandom_range(0, 3) == 0);
      ld_addr = $urandom_range(0, 4 * DEPTH + 7);
      ld_data = $urandom;
      ld_be = 4'($urandom);
      #1;
      n_checks++;
      if (req_ready !== ((q.size() < 2) && !flush))
        $display("FAIL rand_ready c=%0d got %b exp %b", c, req_ready, (q.size() < 2) && !flush);
      else n_pass++;
      n_checks++;
      if (q.size() == 0) begin
        if (rsp_valid !== 1'b0) $display("FAIL rand_valid c=%0d got %b exp 0", c, rsp_valid);
        else n_pass++;
      end else begin
        if ({rsp_valid, rsp_instr, rsp_pc, rsp_fault} !== {1'b1, q[0]})
          $display("FAIL rand_head c=%0d got %b %h/%h/%b exp 1 %h/%h/%b", c,
                   rsp_valid, rsp_instr, rsp_pc, rsp_fault, q[0].instr, q[0].pc, q[0].fault);
        else n_pass++;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 0; req_valid = 1; req_pc = 0;
    tick();
    req_pc = 4;
    tick();
    req_valid = 0;
    #2;
    rst_n = 0;
    q.delete();
    #1;
    n_checks++;
    if ({rsp_valid, req_ready, rsp_instr} !== {2'b00, NOP})
      $display("FAIL midreset got %b%b %h exp 00 %h", rsp_valid, req_ready, rsp_instr, NOP);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1;
    req_valid = 1; req_pc = 0; rsp_ready = 1;
    tick();
    req_valid = 0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_instr, rsp_pc} !== {1'b1, model_mem[0], 32'h0})
      $display("FAIL midreset_mem got %b %h/%h exp 1 %h/0", rsp_valid, rsp_instr, rsp_pc, model_mem[0]);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    init_mem();
    test_basic();
    test_backpressure();
    test_faults();
    test_flush();
    test_rbw();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
